// File: rtl/mon_rule_access_ctrl_pkg.sv
// Shared definitions for the monitoring rule-table access path: defaults common
// to the lookup core and its initiator, the controller state encoding, and a
// small address range helper.
package mon_rule_access_ctrl_pkg;

  localparam int unsigned MON_LUT_DEPTH_BITS_DEF = 5;
  localparam int unsigned TUPLE_WIDTH_DEF        = 104;
  localparam int unsigned LUT_ENTRIES_DEF        = 32;
  localparam int unsigned TIMEOUT_CYCLES_DEF     = 255;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQ_WR   = 2'd1,
    ST_REQ_RD   = 2'd2,
    ST_COMPLETE = 2'd3
  } mon_ctrl_state_e;

  // True when the entry index addresses an implemented table row.
  function automatic logic addr_in_range(input int unsigned addr,
                                         input int unsigned entries);
    return (addr < entries);
  endfunction

endpackage

// File: rtl/mon_rule_access_ctrl_req_timer.sv
// Saturating up-counter that bounds how long a req may wait for its ack.
// clear restarts the count; enable advances it by one per cycle. expire is
// asserted in the cycle whose edge would bring the count to LIMIT, so a caller
// that drops enable when ack arrives lets the ack win over the timeout.
module mon_req_timer #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int unsigned CNT_W = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);
  localparam logic [CNT_W:0]   LIMIT_EXT = (CNT_W + 1)'(LIMIT);
  localparam logic [CNT_W-1:0] LIMIT_CNT = CNT_W'(LIMIT);

  logic [CNT_W-1:0] count;
  logic [CNT_W:0]   count_inc;

  assign count_inc = {1'b0, count} + {{CNT_W{1'b0}}, 1'b1};
  assign expire    = enable && (count_inc >= LIMIT_EXT);

  // Count enabled cycles, holding at LIMIT until the next clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LIMIT_CNT)) begin
      count <= count_inc[CNT_W-1:0];
    end
  end

endmodule

// File: rtl/mon_rule_access_ctrl.sv
// Initiator for the monitoring TCAM rule read/write interface. Accepts one
// command at a time from the register block, runs a level req/ack handshake
// with the lookup core, captures read-back data and reports status.
//
// state       | meaning
// ------------+--------------------------------------------------------------
// ST_IDLE     | waiting for cmd_valid; commands are only accepted here
// ST_REQ_WR   | mon_wr_req held high from latched addr/rule/mask until ack
// ST_REQ_RD   | mon_rd_req held high from latched addr until ack
// ST_COMPLETE | one-cycle done pulse, then back to idle
module mon_rule_access_ctrl
  import mon_rule_access_ctrl_pkg::*;
#(
  parameter int unsigned MON_LUT_DEPTH_BITS = MON_LUT_DEPTH_BITS_DEF,
  parameter int unsigned LUT_ENTRIES        = LUT_ENTRIES_DEF,
  parameter int unsigned TUPLE_WIDTH        = TUPLE_WIDTH_DEF,
  parameter int unsigned TIMEOUT_CYCLES     = TIMEOUT_CYCLES_DEF
) (
  input  logic                          clk,
  input  logic                          reset,

  input  logic                          cmd_valid,
  input  logic                          cmd_wr,
  input  logic [MON_LUT_DEPTH_BITS-1:0] cmd_addr,
  input  logic [TUPLE_WIDTH-1:0]        cmd_rule,
  input  logic [TUPLE_WIDTH-1:0]        cmd_rulemask,

  output logic [MON_LUT_DEPTH_BITS-1:0] mon_rd_addr,
  output logic                          mon_rd_req,
  input  logic [TUPLE_WIDTH-1:0]        mon_rd_rule,
  input  logic [TUPLE_WIDTH-1:0]        mon_rd_rulemask,
  input  logic                          mon_rd_ack,

  output logic [MON_LUT_DEPTH_BITS-1:0] mon_wr_addr,
  output logic                          mon_wr_req,
  output logic [TUPLE_WIDTH-1:0]        mon_wr_rule,
  output logic [TUPLE_WIDTH-1:0]        mon_wr_rulemask,
  input  logic                          mon_wr_ack,

  output logic [TUPLE_WIDTH-1:0]        rd_rule,
  output logic [TUPLE_WIDTH-1:0]        rd_rulemask,
  output logic                          busy,
  output logic                          done,
  output logic                          err_timeout,
  output logic                          err_range,
  output logic                          cmd_overrun
);

  mon_ctrl_state_e               state;
  logic [MON_LUT_DEPTH_BITS-1:0] addr_q;
  logic [TUPLE_WIDTH-1:0]        rule_q;
  logic [TUPLE_WIDTH-1:0]        mask_q;

  logic addr_ok;
  logic cmd_accept;
  logic tmr_enable;
  logic tmr_expire;

  // The latched command drives the interface for the whole req period, so
  // the responder sees stable address/data regardless of the register block.
  assign mon_rd_addr     = addr_q;
  assign mon_wr_addr     = addr_q;
  assign mon_wr_rule     = rule_q;
  assign mon_wr_rulemask = mask_q;

  assign addr_ok    = addr_in_range(32'(cmd_addr), LUT_ENTRIES);
  assign cmd_accept = (state == ST_IDLE) && cmd_valid;

  // The timer only advances while waiting; an ack in the same cycle
  // suppresses expire, so a last-moment ack is treated as success.
  assign tmr_enable = ((state == ST_REQ_WR) && !mon_wr_ack) ||
                      ((state == ST_REQ_RD) && !mon_rd_ack);

  mon_req_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_req_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (cmd_accept),
    .enable (tmr_enable),
    .expire (tmr_expire)
  );

  // Command sequencing FSM with all status and req outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      addr_q      <= '0;
      rule_q      <= '0;
      mask_q      <= '0;
      mon_rd_req  <= 1'b0;
      mon_wr_req  <= 1'b0;
      rd_rule     <= '0;
      rd_rulemask <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err_timeout <= 1'b0;
      err_range   <= 1'b0;
      cmd_overrun <= 1'b0;
    end else begin
      done <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            addr_q      <= cmd_addr;
            rule_q      <= cmd_rule;
            mask_q      <= cmd_rulemask;
            err_timeout <= 1'b0;
            cmd_overrun <= 1'b0;
            if (!addr_ok) begin
              // Out-of-range entries never reach the responder.
              err_range <= 1'b1;
              done      <= 1'b1;
              state     <= ST_COMPLETE;
            end else begin
              err_range <= 1'b0;
              busy      <= 1'b1;
              if (cmd_wr) begin
                mon_wr_req <= 1'b1;
                state      <= ST_REQ_WR;
              end else begin
                mon_rd_req <= 1'b1;
                state      <= ST_REQ_RD;
              end
            end
          end
        end

        ST_REQ_WR: begin
          if (cmd_valid) begin
            cmd_overrun <= 1'b1;
          end
          if (mon_wr_ack) begin
            mon_wr_req <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b1;
            state      <= ST_COMPLETE;
          end else if (tmr_expire) begin
            mon_wr_req  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b1;
            err_timeout <= 1'b1;
            state       <= ST_COMPLETE;
          end
        end

        ST_REQ_RD: begin
          if (cmd_valid) begin
            cmd_overrun <= 1'b1;
          end
          if (mon_rd_ack) begin
            rd_rule     <= mon_rd_rule;
            rd_rulemask <= mon_rd_rulemask;
            mon_rd_req  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b1;
            state       <= ST_COMPLETE;
          end else if (tmr_expire) begin
            mon_rd_req  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b1;
            err_timeout <= 1'b1;
            state       <= ST_COMPLETE;
          end
        end

        ST_COMPLETE: begin
          // Holding here for one cycle also guarantees a req-low gap.
          if (cmd_valid) begin
            cmd_overrun <= 1'b1;
          end
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
